rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_pkg.sv | 13 +
 rtl/rom_arbiter_arb_rr2.sv | 30 +++
 rtl/rom_arbiter.sv | 114 +++++++++++
 tb/tb_rom_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared widths, access-size codes and enums for the two-master ROM arbiter.
package rom_arbiter_pkg;
  localparam int ROM_VA_WIDTH  = 32;
  localparam int BUS_WIDTH     = 32;
  localparam int BUS_ACC_WIDTH = 2;

  localparam logic [BUS_ACC_WIDTH-1:0] ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] ACC_4B = 2'd2;

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} arb_state_e;
  typedef enum logic {M_I = 1'b0, M_D = 1'b1} master_e;
endpackage

// File: rtl/rom_arbiter_arb_rr2.sv
// Two-way grant with a last-served pointer; PRIO_MODE=1 makes ibus win every tie.
module arb_rr2
  import rom_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    req_i,
  input  logic    req_d,
  input  logic    upd,
  input  master_e served,
  output logic    gnt_i,
  output logic    gnt_d
);

  master_e last;

  // Reset to dbus so the first tie goes to ibus.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    last <= M_D;
    else if (upd) last <= served;
  end

  always_comb begin
    gnt_i = req_i & (~req_d | (PRIO_MODE != 0) | (last == M_D));
    gnt_d = req_d & ~gnt_i;
  end

endmodule

// File: rtl/rom_arbiter.sv
// Arbitrates ibus/dbus onto the single rom_controller port, one access outstanding.
//   state   | meaning
//   ST_IDLE | may issue a granted request to the slave this cycle
//   ST_WAIT | one request outstanding, waiting for s_resp
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ROM_VA_WIDTH-1:0]  i_addr,
  input  logic                     i_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] i_acc,
  input  logic [BUS_WIDTH-1:0]     i_wdata,
  input  logic                     i_req,
  output logic [BUS_WIDTH-1:0]     i_rdata,
  output logic                     i_resp,
  output logic                     i_fault,
  input  logic [ROM_VA_WIDTH-1:0]  d_addr,
  input  logic                     d_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] d_acc,
  input  logic [BUS_WIDTH-1:0]     d_wdata,
  input  logic                     d_req,
  output logic [BUS_WIDTH-1:0]     d_rdata,
  output logic                     d_resp,
  output logic                     d_fault,
  output logic [ROM_VA_WIDTH-1:0]  s_addr,
  output logic                     s_w_rb,
  output logic [BUS_ACC_WIDTH-1:0] s_acc,
  output logic [BUS_WIDTH-1:0]     s_wdata,
  output logic                     s_req,
  input  logic [BUS_WIDTH-1:0]     s_rdata,
  input  logic                     s_resp,
  input  logic                     s_fault
);

  arb_state_e state, state_nxt;
  master_e    owner, owner_nxt, served, winner;
  logic       gnt_i, gnt_d, upd;

  arb_rr2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req_i  (i_req),
    .req_d  (d_req),
    .upd    (upd),
    .served (served),
    .gnt_i  (gnt_i),
    .gnt_d  (gnt_d)
  );

  assign winner  = gnt_d ? M_D : M_I;
  assign s_addr  = gnt_d ? d_addr  : i_addr;
  assign s_w_rb  = gnt_d ? d_w_rb  : i_w_rb;
  assign s_acc   = gnt_d ? d_acc   : i_acc;
  assign s_wdata = gnt_d ? d_wdata : i_wdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      owner <= M_I;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  // rstn gating keeps the slave request quiet while reset is held.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    served    = owner;
    upd       = 1'b0;
    s_req     = 1'b0;
    i_resp    = 1'b0;
    d_resp    = 1'b0;
    i_fault   = 1'b0;
    d_fault   = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    case (state)
      ST_IDLE: begin
        if (rstn && (gnt_i || gnt_d)) begin
          s_req = 1'b1;
          if (s_fault) begin
            i_fault = gnt_i;
            d_fault = gnt_d;
            upd     = 1'b1;
            served  = winner;
          end else begin
            owner_nxt = winner;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (s_resp) begin
          if (owner == M_D) begin
            d_resp  = 1'b1;
            d_rdata = s_rdata;
          end else begin
            i_resp  = 1'b1;
            i_rdata = s_rdata;
          end
          upd       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench: round-robin and fixed-priority arbiters, each with a small ROM slave model.
module tb_rom_arbiter;
  import rom_arbiter_pkg::*;

  logic clk, rstn, force_resp;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic        i_w_rb, d_w_rb, i_req, d_req;
  logic [1:0]  i_acc, d_acc;

  logic [31:0] rr_i_rdata, rr_d_rdata, rr_s_addr, rr_s_wdata, rr_s_rdata;
  logic        rr_i_resp, rr_i_fault, rr_d_resp, rr_d_fault, rr_s_w_rb, rr_s_req, rr_s_resp, rr_s_fault;
  logic [1:0]  rr_s_acc;
  logic [31:0] fp_i_rdata, fp_d_rdata, fp_s_addr, fp_s_wdata, fp_s_rdata;
  logic        fp_i_resp, fp_i_fault, fp_d_resp, fp_d_fault, fp_s_w_rb, fp_s_req, fp_s_resp, fp_s_fault;
  logic [1:0]  fp_s_acc;

  logic        rr_resp_q, fp_resp_q;
  logic [31:0] rr_rdata_q, fp_rdata_q;
  int n_assert = 0, n_fail = 0;

  rom_arbiter #(.PRIO_MODE(0)) dut_rr (
    .clk(clk), .rstn(rstn),
    .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_wdata(i_wdata), .i_req(i_req),
    .i_rdata(rr_i_rdata), .i_resp(rr_i_resp), .i_fault(rr_i_fault),
    .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
    .d_rdata(rr_d_rdata), .d_resp(rr_d_resp), .d_fault(rr_d_fault),
    .s_addr(rr_s_addr), .s_w_rb(rr_s_w_rb), .s_acc(rr_s_acc), .s_wdata(rr_s_wdata), .s_req(rr_s_req),
    .s_rdata(rr_s_rdata), .s_resp(rr_s_resp), .s_fault(rr_s_fault));

  rom_arbiter #(.PRIO_MODE(1)) dut_fp (
    .clk(clk), .rstn(rstn),
    .i_addr(i_addr), .i_w_rb(i_w_rb), .i_acc(i_acc), .i_wdata(i_wdata), .i_req(i_req),
    .i_rdata(fp_i_rdata), .i_resp(fp_i_resp), .i_fault(fp_i_fault),
    .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
    .d_rdata(fp_d_rdata), .d_resp(fp_d_resp), .d_fault(fp_d_fault),
    .s_addr(fp_s_addr), .s_w_rb(fp_s_w_rb), .s_acc(fp_s_acc), .s_wdata(fp_s_wdata), .s_req(fp_s_req),
    .s_rdata(fp_s_rdata), .s_resp(fp_s_resp), .s_fault(fp_s_fault));

  // ROM word n reads as A000_0000 + n; writes and misaligned accesses fault.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'hA000_0000 + (a >> 2);
  endfunction

  function automatic logic bad(input logic w, input logic [31:0] a, input logic [1:0] acc);
    return w | ((acc == ACC_2B) & a[0]) | ((acc == ACC_4B) & (a[1:0] != 2'b00));
  endfunction

  assign rr_s_fault = rr_s_req & bad(rr_s_w_rb, rr_s_addr, rr_s_acc);
  assign fp_s_fault = fp_s_req & bad(fp_s_w_rb, fp_s_addr, fp_s_acc);
  assign rr_s_resp  = rr_resp_q | force_resp;
  assign fp_s_resp  = fp_resp_q;
  assign rr_s_rdata = rr_resp_q ? rr_rdata_q : 32'h0;
  assign fp_s_rdata = fp_resp_q ? fp_rdata_q : 32'h0;

  always @(posedge clk) begin
    rr_resp_q  <= rr_s_req & ~rr_s_fault;
    rr_rdata_q <= rom_word(rr_s_addr);
    fp_resp_q  <= fp_s_req & ~fp_s_fault;
    fp_rdata_q <= rom_word(fp_s_addr);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_edge();
    rstn = 1'b0; i_req = 1'b0; d_req = 1'b0; i_w_rb = 1'b0; d_w_rb = 1'b0;
    drive_edge();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; force_resp = 1'b0;
    i_addr = '0; d_addr = '0; i_wdata = 32'h1111_1111; d_wdata = 32'h2222_2222;
    i_w_rb = 1'b0; d_w_rb = 1'b0; i_acc = ACC_4B; d_acc = ACC_4B;
    i_req = 1'b1; d_req = 1'b1;

    // Requests held during reset must not reach the slave.
    @(negedge clk);
    chk("rst_s_req", rr_s_req, 0);
    chk("rst_i_resp", rr_i_resp, 0);
    chk("rst_d_resp", rr_d_resp, 0);
    chk("rst_i_fault", rr_i_fault, 0);
    chk("rst_d_fault", rr_d_fault, 0);
    i_req = 1'b0; d_req = 1'b0;
    drive_edge();
    rstn = 1'b1;

    // Single ibus read of word 4.
    drive_edge();
    i_req = 1'b1; i_addr = 32'h010; i_acc = ACC_4B;
    @(negedge clk);
    chk("t1_s_req", rr_s_req, 1);
    chk("t1_s_addr", rr_s_addr, 32'h010);
    chk("t1_s_wdata", rr_s_wdata, 32'h1111_1111);
    drive_edge();
    @(negedge clk);
    chk("t1_wait_s_req", rr_s_req, 0);
    chk("t1_i_resp", rr_i_resp, 1);
    chk("t1_i_rdata", rr_i_rdata, 32'hA000_0004);
    chk("t1_d_resp", rr_d_resp, 0);
    drive_edge();
    i_req = 1'b0;
    @(negedge clk);
    chk("t1_idle_s_req", rr_s_req, 0);
    chk("t1_idle_i_resp", rr_i_resp, 0);

    // Simultaneous requests after reset: ibus first, dbus on the next IDLE cycle.
    do_reset();
    drive_edge();
    i_req = 1'b1; i_addr = 32'h020; d_req = 1'b1; d_addr = 32'h044; d_acc = ACC_4B;
    @(negedge clk);
    chk("t2_g1_s_req", rr_s_req, 1);
    chk("t2_g1_s_addr", rr_s_addr, 32'h020);
    drive_edge();
    @(negedge clk);
    chk("t2_r1_s_req", rr_s_req, 0);
    chk("t2_r1_i_resp", rr_i_resp, 1);
    chk("t2_r1_i_rdata", rr_i_rdata, 32'hA000_0008);
    chk("t2_r1_d_resp", rr_d_resp, 0);
    chk("t2_r1_d_rdata", rr_d_rdata, 0);
    drive_edge();
    i_req = 1'b0;
    @(negedge clk);
    chk("t2_g2_s_req", rr_s_req, 1);
    chk("t2_g2_s_addr", rr_s_addr, 32'h044);
    drive_edge();
    @(negedge clk);
    chk("t2_r2_d_resp", rr_d_resp, 1);
    chk("t2_r2_d_rdata", rr_d_rdata, 32'hA000_0011);
    chk("t2_r2_i_resp", rr_i_resp, 0);
    drive_edge();
    d_req = 1'b0;

    // Both held for 8 cycles: rr alternates I,D,I,D; fixed priority never serves D.
    do_reset();
    drive_edge();
    i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_addr = 32'h200;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("t3_rr_s_req_c%0d", c), rr_s_req, (c % 2 == 0));
      chk($sformatf("t3_fp_s_req_c%0d", c), fp_s_req, (c % 2 == 0));
      chk($sformatf("t3_fp_d_resp_c%0d", c), fp_d_resp, 0);
      if (c % 2 == 0) begin
        chk($sformatf("t3_rr_s_addr_c%0d", c), rr_s_addr, (c % 4 == 0) ? 32'h100 : 32'h200);
        chk($sformatf("t3_fp_s_addr_c%0d", c), fp_s_addr, 32'h100);
      end else begin
        chk($sformatf("t3_rr_i_resp_c%0d", c), rr_i_resp, (c % 4 == 1));
        chk($sformatf("t3_rr_d_resp_c%0d", c), rr_d_resp, (c % 4 == 3));
        chk($sformatf("t3_fp_i_resp_c%0d", c), fp_i_resp, 1);
      end
      drive_edge();
    end
    i_req = 1'b0; d_req = 1'b0;

    // dbus write faults in its grant cycle; pending ibus is granted the next cycle.
    do_reset();
    drive_edge();
    i_req = 1'b1; i_addr = 32'h008;
    drive_edge();
    drive_edge();
    i_req = 1'b0;
    drive_edge();
    i_req = 1'b1; i_addr = 32'h00C; d_req = 1'b1; d_w_rb = 1'b1; d_addr = 32'h040;
    @(negedge clk);
    chk("t4_s_req", rr_s_req, 1);
    chk("t4_s_w_rb", rr_s_w_rb, 1);
    chk("t4_s_addr", rr_s_addr, 32'h040);
    chk("t4_d_fault", rr_d_fault, 1);
    chk("t4_i_fault", rr_i_fault, 0);
    drive_edge();
    d_req = 1'b0; d_w_rb = 1'b0;
    @(negedge clk);
    chk("t4_i_grant_s_req", rr_s_req, 1);
    chk("t4_i_grant_s_addr", rr_s_addr, 32'h00C);
    chk("t4_d_resp", rr_d_resp, 0);
    chk("t4_d_fault_clr", rr_d_fault, 0);
    drive_edge();
    @(negedge clk);
    chk("t4_i_resp", rr_i_resp, 1);
    chk("t4_i_rdata", rr_i_rdata, 32'hA000_0003);
    drive_edge();
    i_req = 1'b0;

    // Misaligned halfword read faults on dbus only.
    drive_edge();
    d_req = 1'b1; d_addr = 32'h003; d_acc = ACC_2B;
    @(negedge clk);
    chk("t5_s_req", rr_s_req, 1);
    chk("t5_d_fault", rr_d_fault, 1);
    chk("t5_i_fault", rr_i_fault, 0);
    chk("t5_i_resp", rr_i_resp, 0);
    chk("t5_i_rdata", rr_i_rdata, 0);
    drive_edge();
    d_req = 1'b0; d_acc = ACC_4B;
    @(negedge clk);
    chk("t5_after_s_req", rr_s_req, 0);
    chk("t5_after_d_resp", rr_d_resp, 0);

    // Reset during WAIT abandons the access; stray s_resp after deassert is ignored.
    do_reset();
    drive_edge();
    i_req = 1'b1; i_addr = 32'h014; d_addr = 32'h018;
    @(negedge clk);
    chk("t6_g_s_req", rr_s_req, 1);
    drive_edge();
    rstn = 1'b0; d_req = 1'b1;
    @(negedge clk);
    chk("t6_rst_i_resp", rr_i_resp, 0);
    chk("t6_rst_d_resp", rr_d_resp, 0);
    chk("t6_rst_s_req", rr_s_req, 0);
    drive_edge();
    rstn = 1'b1; force_resp = 1'b1;
    @(negedge clk);
    chk("t6_stray_i_resp", rr_i_resp, 0);
    chk("t6_stray_d_resp", rr_d_resp, 0);
    chk("t6_tie_s_req", rr_s_req, 1);
    chk("t6_tie_s_addr", rr_s_addr, 32'h014);
    drive_edge();
    force_resp = 1'b0;
    @(negedge clk);
    chk("t6_i_resp", rr_i_resp, 1);
    chk("t6_i_rdata", rr_i_rdata, 32'hA000_0005);
    chk("t6_d_resp", rr_d_resp, 0);
    drive_edge();
    i_req = 1'b0; d_req = 1'b0;
    drive_edge();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
